// File: rtl/ctrl_encode_def.sv
// Shared encodings for the PC sequencer: NPC selection codes, FSM state codes and
// a small alignment helper used when accepting the NPC unit's result.
package ctrl_encode_def;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } seq_state_e;

    localparam int DEFAULT_TIMEOUT = 16;

    function automatic logic isWordAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_timer.sv
// Counts consecutive fetch-request cycles without an acknowledge and flags the
// cycle in which the wait budget is used up.
module pc_fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Saturates at LAST so a lingering request can never wrap back to an early count.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetches over req/ack, holds the instruction until the
// datapath finishes, steers the NPC unit and loads its result into the PC.
module pc_sequencer
    import ctrl_encode_def::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [1:0]  dec_npc_op,
    input  logic        branch_taken,
    input  logic [31:0] npc,
    output logic [1:0]  npc_op_o,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fetch_err,
    output logic [31:0] retired_cnt
);

    seq_state_e  r_state;
    logic        r_rstQ;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_fetchErr;
    logic [31:0] r_retired;

    logic        w_fetchActive;
    logic        w_timerExpire;
    logic [1:0]  w_npcOp;

    // The request stays low for one cycle after reset so a stale ack cannot be taken.
    assign w_fetchActive = (r_state == S_FETCH) && !r_rstQ;

    pc_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_fetchActive || imem_ack),
        .i_count  (w_fetchActive && !imem_ack),
        .o_expire (w_timerExpire)
    );

    always_comb begin
        w_npcOp = NPC_PLUS4;
        if (r_state == S_EXEC) begin
            if ((dec_npc_op == NPC_BRANCH) && !branch_taken) begin
                w_npcOp = NPC_PLUS4;
            end else begin
                w_npcOp = dec_npc_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_rstQ     <= 1'b1;
            r_pc       <= RESET_VEC;
            r_instr    <= '0;
            r_fetchErr <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_rstQ <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (w_fetchActive) begin
                        // An ack always wins over a simultaneous halt or timeout.
                        if (imem_ack) begin
                            r_instr <= imem_rdata;
                            r_state <= S_EXEC;
                        end else if (w_timerExpire) begin
                            r_fetchErr <= 1'b1;
                            r_state    <= S_HALT;
                        end else if (halt) begin
                            r_state <= S_HALT;
                        end
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (!isWordAligned(npc)) begin
                            r_fetchErr <= 1'b1;
                            r_state    <= S_HALT;
                        end else begin
                            r_pc      <= npc;
                            r_retired <= r_retired + 32'd1;
                            r_state   <= halt ? S_HALT : S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req    = w_fetchActive;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_EXEC);
    assign npc_op_o    = w_npcOp;
    assign pc          = r_pc;
    assign halted      = (r_state == S_HALT);
    assign fetch_err   = r_fetchErr;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural NPC unit feeding npc.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  dec_npc_op;
    logic        branch_taken;
    logic [31:0] npc;
    logic [1:0]  npc_op_o;
    logic        halt;
    logic [31:0] pc;
    logic        halted;
    logic        fetch_err;
    logic [31:0] retired_cnt;

    logic [31:0] tbTarget;
    int          testsRun;
    int          testsFailed;

    pc_sequencer #(
        .RESET_VEC (32'h0000_0000),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .dec_npc_op   (dec_npc_op),
        .branch_taken (branch_taken),
        .npc          (npc),
        .npc_op_o     (npc_op_o),
        .halt         (halt),
        .pc           (pc),
        .halted       (halted),
        .fetch_err    (fetch_err),
        .retired_cnt  (retired_cnt)
    );

    // NPC unit stand-in: sequential PC for PLUS4, otherwise the target the test sets up.
    assign npc = (npc_op_o == 2'b00) ? (pc + 32'd4) : tbTarget;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst          = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        exec_done    = 1'b0;
        dec_npc_op   = 2'b00;
        branch_taken = 1'b0;
        halt         = 1'b0;
        tbTarget     = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        testsRun++; if (pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0); end
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req_first: got %b want 0", imem_req); end
        testsRun++; if (instr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
        testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
        testsRun++; if (halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        testsRun++; if (fetch_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b want 0", fetch_err); end
        testsRun++; if (retired_cnt !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_cnt: got %h want 0", retired_cnt); end
        testsRun++; if (npc_op_o !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_npcop: got %b want 00", npc_op_o); end
        step();
        testsRun++; if (imem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_req_second: got %b want 1", imem_req); end
        testsRun++; if (imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_fetch_exec();
        imem_ack = 1'b0;
        step();
        testsRun++; if (imem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL fe_req_wait: got %b want 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0;
        testsRun++; if (instr_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL fe_valid: got %b want 1", instr_valid); end
        testsRun++; if (instr !== 32'h2008_0005) begin testsFailed++; $display("[TB] FAIL fe_instr: got %h want %h", instr, 32'h2008_0005); end
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL fe_req_exec: got %b want 0", imem_req); end
        dec_npc_op = 2'b00; exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        testsRun++; if (pc !== 32'h4) begin testsFailed++; $display("[TB] FAIL fe_pc: got %h want %h", pc, 32'h4); end
        testsRun++; if (retired_cnt !== 32'd1) begin testsFailed++; $display("[TB] FAIL fe_cnt: got %0d want 1", retired_cnt); end
        testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fe_valid_after: got %b want 0", instr_valid); end
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin testsFailed++; $display("[TB] FAIL fe_second_fetch: got req %b addr %h want req 1 addr %h", imem_req, imem_addr, 32'h4); end
    endtask

    task automatic test_branch();
        imem_ack = 1'b1; imem_rdata = 32'h1000_0003;
        step();
        imem_ack = 1'b0;
        dec_npc_op = 2'b01; branch_taken = 1'b0; tbTarget = 32'h40;
        #1;
        testsRun++; if (npc_op_o !== 2'b00) begin testsFailed++; $display("[TB] FAIL br_nt_op: got %b want 00", npc_op_o); end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        testsRun++; if (pc !== 32'h8) begin testsFailed++; $display("[TB] FAIL br_nt_pc: got %h want %h", pc, 32'h8); end
        testsRun++; if (npc_op_o !== 2'b00) begin testsFailed++; $display("[TB] FAIL br_fetch_op: got %b want 00", npc_op_o); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        branch_taken = 1'b1;
        #1;
        testsRun++; if (npc_op_o !== 2'b01) begin testsFailed++; $display("[TB] FAIL br_t_op: got %b want 01", npc_op_o); end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0; branch_taken = 1'b0; dec_npc_op = 2'b00;
        testsRun++; if (pc !== 32'h40) begin testsFailed++; $display("[TB] FAIL br_t_pc: got %h want %h", pc, 32'h40); end
        testsRun++; if (retired_cnt !== 32'd3) begin testsFailed++; $display("[TB] FAIL br_cnt: got %0d want 3", retired_cnt); end
        testsRun++; if (imem_addr !== 32'h40) begin testsFailed++; $display("[TB] FAIL br_addr: got %h want %h", imem_addr, 32'h40); end
    endtask

    task automatic test_misaligned_jr();
        imem_ack = 1'b1; imem_rdata = 32'h03E0_0008;
        step();
        imem_ack = 1'b0;
        dec_npc_op = 2'b11; tbTarget = 32'h0000_0102;
        #1;
        testsRun++; if (npc_op_o !== 2'b11) begin testsFailed++; $display("[TB] FAIL jr_op: got %b want 11", npc_op_o); end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0; dec_npc_op = 2'b00;
        testsRun++; if (fetch_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL jr_err: got %b want 1", fetch_err); end
        testsRun++; if (halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL jr_halted: got %b want 1", halted); end
        testsRun++; if (pc !== 32'h40) begin testsFailed++; $display("[TB] FAIL jr_pc: got %h want %h", pc, 32'h40); end
        testsRun++; if (retired_cnt !== 32'd3) begin testsFailed++; $display("[TB] FAIL jr_cnt: got %0d want 3", retired_cnt); end
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        testsRun++; if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL jr_frozen: got req %b halted %b valid %b want 0 1 0", imem_req, halted, instr_valid); end
    endtask

    task automatic test_timeout();
        doReset();
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) step();
        testsRun++; if (halted !== 1'b0 || imem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_before: got halted %b req %b want 0 1", halted, imem_req); end
        step();
        testsRun++; if (fetch_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_err: got %b want 1", fetch_err); end
        testsRun++; if (halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_halted: got %b want 1", halted); end
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_req: got %b want 0", imem_req); end
        testsRun++; if (pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL to_pc: got %h want 0", pc); end
    endtask

    task automatic test_halt_exec();
        doReset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0; halt = 1'b1;
        step();
        step();
        step();
        testsRun++; if (instr_valid !== 1'b1 || halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL he_hold: got valid %b halted %b want 1 0", instr_valid, halted); end
        testsRun++; if (retired_cnt !== 32'd0) begin testsFailed++; $display("[TB] FAIL he_cnt_hold: got %0d want 0", retired_cnt); end
        exec_done = 1'b1; dec_npc_op = 2'b00;
        step();
        exec_done = 1'b0;
        testsRun++; if (pc !== 32'h4) begin testsFailed++; $display("[TB] FAIL he_pc: got %h want %h", pc, 32'h4); end
        testsRun++; if (retired_cnt !== 32'd1) begin testsFailed++; $display("[TB] FAIL he_cnt: got %0d want 1", retired_cnt); end
        testsRun++; if (halted !== 1'b1 || fetch_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL he_halted: got halted %b err %b want 1 0", halted, fetch_err); end
        halt = 1'b0;
        step();
        step();
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL he_req: got %b want 0", imem_req); end
    endtask

    task automatic test_halt_fetch();
        doReset();
        step();
        halt = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0011;
        step();
        halt = 1'b0; imem_ack = 1'b0;
        testsRun++; if (instr_valid !== 1'b1 || halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL hf_ackwins: got valid %b halted %b want 1 0", instr_valid, halted); end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        testsRun++; if (halted !== 1'b1 || fetch_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL hf_halt: got halted %b err %b want 1 0", halted, fetch_err); end
        testsRun++; if (pc !== 32'h4 || retired_cnt !== 32'd1) begin testsFailed++; $display("[TB] FAIL hf_state: got pc %h cnt %0d want 4 1", pc, retired_cnt); end
    endtask

    task automatic test_back_to_back();
        doReset();
        step();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
            step();
            imem_ack = 1'b0; exec_done = 1'b1;
            step();
            exec_done = 1'b0;
        end
        testsRun++; if (pc !== 32'hC) begin testsFailed++; $display("[TB] FAIL b2b_pc: got %h want %h", pc, 32'hC); end
        testsRun++; if (retired_cnt !== 32'd3) begin testsFailed++; $display("[TB] FAIL b2b_cnt: got %0d want 3", retired_cnt); end
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin testsFailed++; $display("[TB] FAIL b2b_fetch: got req %b addr %h want 1 %h", imem_req, imem_addr, 32'hC); end
    endtask

    task automatic test_reset_mid_fetch();
        doReset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0; exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        testsRun++; if (imem_addr !== 32'h4) begin testsFailed++; $display("[TB] FAIL rmf_pre: got %h want %h", imem_addr, 32'h4); end
        rst = 1'b1;
        step();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        testsRun++; if (imem_req !== 1'b0 || pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL rmf_reset: got req %b pc %h want 0 0", imem_req, pc); end
        step();
        imem_ack = 1'b0;
        testsRun++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin testsFailed++; $display("[TB] FAIL rmf_stale: got valid %b instr %h want 0 0", instr_valid, instr); end
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL rmf_refetch: got req %b addr %h want 1 0", imem_req, imem_addr); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_fetch_exec();
        test_branch();
        test_misaligned_jr();
        test_timeout();
        test_halt_exec();
        test_halt_fetch();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
